// File: rtl/wb_uart_tx_if.sv
// wb_uart_tx_if: Wishbone classic bus bundle between the intercon master and the UART transmitter slave
interface wb_uart_tx_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, input wb_dat_o, wb_ack_o);
  modport slave (input wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave that queues bytes in a FIFO and sends them as 8N1 UART frames
module wb_uart_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  wb_uart_tx_if.slave wb,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      r_state, w_state;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [LW-1:0] r_lvl;
  logic [15:0] r_div, r_bdiv, w_bdiv, r_cnt, w_cnt, w_div_eff;
  logic [2:0]  r_idx, w_idx;
  logic [7:0]  r_sh, w_sh;
  logic        r_ie, r_ovf, r_ack, r_irq;
  logic [31:0] r_dat, w_rd, w_status;
  logic        w_req, w_wr, w_push, w_pop, w_acc, w_full, w_empty, w_busy, w_tick;
  logic [1:0]  w_reg;
  logic        w_unused;
  assign w_unused  = &{1'b0, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2]};
  assign w_reg     = wb.wb_adr_i[3:2];
  assign w_req     = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack;
  assign w_wr      = w_req & wb.wb_we_i;
  assign w_full    = r_lvl == LW'(FIFO_DEPTH);
  assign w_empty   = r_lvl == '0;
  assign w_busy    = r_state != IDLE;
  assign w_push    = w_wr & (w_reg == 2'd0) & wb.wb_sel_i[0];
  // a full FIFO still takes the byte when the transmitter pops in the same cycle
  assign w_acc     = w_push & (~w_full | w_pop);
  assign w_div_eff = (r_div < 16'd2) ? 16'd2 : r_div;
  assign w_tick    = r_cnt == r_bdiv - 16'd1;
  assign w_status  = (32'(r_lvl) << 8) | {28'h0, r_ovf, w_busy, w_empty, w_full};
  assign w_rd      = (w_reg == 2'd1) ? w_status :
                     (w_reg == 2'd2) ? {16'h0, r_div} :
                     (w_reg == 2'd3) ? {31'h0, r_ie} : 32'h0;
  assign tx_o         = (r_state == START) ? 1'b0 : (r_state == DATA) ? r_sh[0] : 1'b1;
  assign irq_o        = r_irq;
  assign wb.wb_ack_o  = r_ack;
  assign wb.wb_dat_o  = r_dat;
  // frame sequencer: each state lasts one latched divisor period per bit; STOP chains straight into the next START
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt + 16'd1;
    w_idx   = r_idx;
    w_sh    = r_sh;
    w_bdiv  = r_bdiv;
    w_pop   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          w_state = START;
        end
      end
      START: if (w_tick) begin
        w_cnt   = '0;
        w_idx   = '0;
        w_state = DATA;
      end
      DATA: if (w_tick) begin
        w_cnt   = '0;
        w_idx   = r_idx + 3'd1;
        w_sh    = r_sh >> 1;
        w_state = (r_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (w_tick) begin
        w_cnt   = '0;
        w_pop   = ~w_empty;
        w_state = w_empty ? IDLE : START;
      end
      default: w_state = IDLE;
    endcase
    if (w_pop) begin
      w_sh   = r_mem[r_rp];
      w_bdiv = w_div_eff;
    end
  end
  // sequencer registers; reset abandons any frame in progress
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_sh    <= '0;
      r_bdiv  <= 16'd2;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_sh    <= w_sh;
      r_bdiv  <= w_bdiv;
    end
  end
  // FIFO storage, written only for accepted bytes
  always_ff @(posedge clk_i) begin
    if (w_acc) r_mem[r_wp] <= wb.wb_dat_i[7:0];
  end
  // FIFO pointers and level; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_acc);
      r_rp  <= r_rp + AW'(w_pop);
      r_lvl <= r_lvl + LW'(w_acc) - LW'(w_pop);
    end
  end
  // bus acknowledge, registered read data, control registers and interrupt
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
      r_div <= DIV_RESET;
      r_ie  <= 1'b0;
      r_ovf <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !wb.wb_we_i) ? w_rd : 32'h0;
      r_irq <= r_ie & w_empty & ~w_busy;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr && w_reg == 2'd1 && wb.wb_sel_i[0] && wb.wb_dat_i[3]) r_ovf <= 1'b0;
      if (w_wr && w_reg == 2'd2 && wb.wb_sel_i[0]) r_div[7:0] <= wb.wb_dat_i[7:0];
      if (w_wr && w_reg == 2'd2 && wb.wb_sel_i[1]) r_div[15:8] <= wb.wb_dat_i[15:8];
      if (w_wr && w_reg == 2'd3 && wb.wb_sel_i[0]) r_ie <= wb.wb_dat_i[0];
    end
  end
endmodule
